// File: rtl/uart_rx_cfg_if.sv
// Byte-stream handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_cfg_if #(
  parameter int N_BITS = 8
);
  logic [N_BITS-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop input synchroniser, run-time baud divisor,
// 5..9 data bits, 1 or 2 stop bits, framing/overrun pulses.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the data
// bits and drives parity_err (odd or even per PARITY_ODD).
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int N_BITS     = 8,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_data,
  input  logic [DIV_W-1:0] baud_div,
  uart_rx_cfg_if.master    m_axis,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int N_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int BW      = $clog2(N_BITS + 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Expected parity bit for a data word.
  function automatic logic calc_parity(input logic [N_BITS-1:0] data);
    calc_parity = (^data) ^ (PARITY_ODD != 0);
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;
`endif

  state_t            state_q, state_d;
  logic              sync1_q, rxs_q;
  logic [DIV_W-1:0]  tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [N_BITS-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic [N_BITS-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic [DIV_W-1:0]  eff_div;
  logic [DIV_W-1:0]  half_div;
  logic              bit_end;
`ifdef UART_RX_PARITY_EN
  logic              pbad_q, pbad_d;
  logic              parity_err_q, parity_err_d;
`endif

  // Two-flop synchroniser on the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx_data;
      rxs_q   <= sync1_q;
    end
  end

  // Effective divisor: 0 picks the compile-time rate, tiny values clamp to 4.
  always_comb begin
    if (baud_div == {DIV_W{1'b0}}) begin
      eff_div = DIV_W'(N_TICKS);
    end else if (baud_div < DIV_W'(4)) begin
      eff_div = DIV_W'(4);
    end else begin
      eff_div = baud_div;
    end
  end

  assign half_div = (div_q - DIV_W'(1)) >> 1;
  assign bit_end  = (tick_q == (div_q - DIV_W'(1)));

  // Next-state, datapath and output-register decisions for the receive FSM.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    div_d       = div_q;
    shift_d     = shift_q;
    ferr_d      = ferr_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q & ~m_axis.tready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d       = pbad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d = {DIV_W{1'b0}};
        bit_d  = {BW{1'b0}};
        if (!rxs_q) begin
          state_d = S_START;
          div_d   = eff_div;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tick_q == half_div) begin
          tick_d = {DIV_W{1'b0}};
          bit_d  = {BW{1'b0}};
          // A high line at mid-start is a glitch, not a frame.
          if (!rxs_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tick_d  = {DIV_W{1'b0}};
          // LSB arrives first: shifting in from the top leaves it at bit 0.
          shift_d = {rxs_q, shift_q[N_BITS-1:1]};
          if (bit_q == BW'(N_BITS - 1)) begin
            bit_d   = {BW{1'b0}};
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          tick_d  = {DIV_W{1'b0}};
          pbad_d  = rxs_q ^ calc_parity(shift_q);
          state_d = S_STOP;
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          tick_d = {DIV_W{1'b0}};
          if (!rxs_q) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = ferr_q;
          end
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = {BW{1'b0}};
            state_d = S_DONE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ferr_q) begin
          frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        end else if (pbad_q) begin
          parity_err_d = 1'b1;
`endif
        end else if (!tvalid_q || m_axis.tready) begin
          tdata_d  = shift_q;
          tvalid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_q      <= {DIV_W{1'b0}};
      bit_q       <= {BW{1'b0}};
      div_q       <= DIV_W'(4);
      shift_q     <= {N_BITS{1'b0}};
      ferr_q      <= 1'b0;
      tdata_q     <= {N_BITS{1'b0}};
      tvalid_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag and its one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pbad_q       <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      pbad_q       <= pbad_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign frame_err     = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: dut_a is 8N1, dut_b uses two stop bits.
module tb_uart_rx_cfg;
  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_a, rx_b;
  logic [15:0] div_a, div_b;
  logic        fe_a, ov_a, pe_a, fe_b, ov_b, pe_b;

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt_a = 0, ov_cnt_a = 0, pe_cnt_a = 0, tv_cyc_a = 0;
  int fe_cnt_b = 0, ov_cnt_b = 0, pe_cnt_b = 0, tv_cyc_b = 0;
  logic [NB-1:0] q_a[$];
  logic [NB-1:0] q_b[$];

  uart_rx_cfg_if #(.N_BITS(NB)) a_if ();
  uart_rx_cfg_if #(.N_BITS(NB)) b_if ();

  uart_rx_cfg #(.STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_a), .baud_div(div_a), .m_axis(a_if),
    .frame_err(fe_a), .overrun(ov_a), .parity_err(pe_a)
  );

  uart_rx_cfg #(.STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_b), .baud_div(div_b), .m_axis(b_if),
    .frame_err(fe_b), .overrun(ov_b), .parity_err(pe_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: count pulses and valid cycles, pop the scoreboard on handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (fe_a) fe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (pe_a) pe_cnt_a++;
      if (fe_b) fe_cnt_b++;
      if (ov_b) ov_cnt_b++;
      if (pe_b) pe_cnt_b++;
      if (a_if.tvalid) tv_cyc_a++;
      if (b_if.tvalid) tv_cyc_b++;
      if (a_if.tvalid && a_if.tready) begin
        if (q_a.size() == 0) check_eq("a_extra_word", 32'(q_a.size()), 32'd1);
        else check_eq("a_tdata", 32'(a_if.tdata), 32'(q_a.pop_front()));
      end
      if (b_if.tvalid && b_if.tready) begin
        if (q_b.size() == 0) check_eq("b_extra_word", 32'(q_b.size()), 32'd1);
        else check_eq("b_tdata", 32'(b_if.tdata), 32'(q_b.pop_front()));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic drive_bit(input int sel, input logic v, input int d);
    set_rx(sel, v);
    wait_cyc(d);
  endtask

  // par < 0 sends the correct even parity bit (parity builds only).
  task automatic send_frame(input int sel, input logic [NB-1:0] data, input int d,
                            input int n_stop, input logic stop_val, input int par);
    logic pb;
    pb = (par < 0) ? ^data : par[0];
    drive_bit(sel, 1'b0, d);
    for (int i = 0; i < NB; i++) drive_bit(sel, data[i], d);
`ifdef UART_RX_PARITY_EN
    drive_bit(sel, pb, d);
`else
    pb = 1'b0;
`endif
    for (int i = 0; i < n_stop; i++) drive_bit(sel, stop_val, d);
    set_rx(sel, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    div_a = 16'd0; div_b = 16'd0;
    a_if.tready = 1'b0; b_if.tready = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);

    // Reset state
    check_eq("rst_tvalid_a", 32'(a_if.tvalid), 32'd0);
    check_eq("rst_tdata_a", 32'(a_if.tdata), 32'd0);
    check_eq("rst_errs_a", {29'd0, fe_a, ov_a, pe_a}, 32'd0);
    check_eq("rst_tvalid_b", 32'(b_if.tvalid), 32'd0);

    // Default rate, 0xA5
    a_if.tready = 1'b1;
    q_a.push_back(8'hA5);
    send_frame(0, 8'hA5, 217, 1, 1'b1, -1);
    wait_cyc(20);
    check_eq("a5_valid_cycles", 32'(tv_cyc_a), 32'd1);
    check_eq("a5_no_errs", 32'(fe_cnt_a + ov_cnt_a + pe_cnt_a), 32'd0);

    // Short low glitch is rejected
    rx_a = 1'b0;
    wait_cyc(50);
    rx_a = 1'b1;
    wait_cyc(3 * 217);
    check_eq("glitch_no_valid", 32'(tv_cyc_a), 32'd1);
    check_eq("glitch_no_errs", 32'(fe_cnt_a + ov_cnt_a + pe_cnt_a), 32'd0);

    // Framing error then a clean frame
    div_a = 16'd16;
    send_frame(0, 8'h3C, 16, 1, 1'b0, -1);
    wait_cyc(48);
    check_eq("ferr_pulse", 32'(fe_cnt_a), 32'd1);
    check_eq("ferr_no_valid", 32'(tv_cyc_a), 32'd1);
    q_a.push_back(8'h3C);
    send_frame(0, 8'h3C, 16, 1, 1'b1, -1);
    wait_cyc(20);
    check_eq("3c_valid_cycles", 32'(tv_cyc_a), 32'd2);
    check_eq("3c_ferr_total", 32'(fe_cnt_a), 32'd1);

    // Overrun: consumer stalled, two back-to-back frames
    a_if.tready = 1'b0;
    q_a.push_back(8'h11);
    send_frame(0, 8'h11, 16, 1, 1'b1, -1);
    send_frame(0, 8'h22, 16, 1, 1'b1, -1);
    wait_cyc(20);
    check_eq("ovr_tvalid_held", 32'(a_if.tvalid), 32'd1);
    check_eq("ovr_tdata_held", 32'(a_if.tdata), 32'h11);
    check_eq("ovr_pulse", 32'(ov_cnt_a), 32'd1);
    a_if.tready = 1'b1;
    wait_cyc(1);
    a_if.tready = 1'b0;
    wait_cyc(1);
    check_eq("ovr_tvalid_drop", 32'(a_if.tvalid), 32'd0);
    a_if.tready = 1'b1;

    // Small divisor clamps to 4
    div_a = 16'd2;
    q_a.push_back(8'h81);
    send_frame(0, 8'h81, 4, 1, 1'b1, -1);
    wait_cyc(20);
    check_eq("clamp_queue_empty", 32'(q_a.size()), 32'd0);

    // Two stop bits, no idle gap, then reset mid-frame
    div_b = 16'd27;
    b_if.tready = 1'b1;
    q_b.push_back(8'h5A);
    q_b.push_back(8'hFF);
    send_frame(1, 8'h5A, 27, 2, 1'b1, -1);
    send_frame(1, 8'hFF, 27, 2, 1'b1, -1);
    wait_cyc(20);
    check_eq("b2b_valid_cycles", 32'(tv_cyc_b), 32'd2);
    check_eq("b2b_queue_empty", 32'(q_b.size()), 32'd0);
    drive_bit(1, 1'b0, 27);
    drive_bit(1, 1'b0, 27);
    drive_bit(1, 1'b1, 27);
    rst = 1'b1;
    rx_b = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(4 * 27);
    check_eq("rst_mid_no_valid", 32'(tv_cyc_b), 32'd2);
    check_eq("rst_mid_no_errs", 32'(fe_cnt_b + ov_cnt_b + pe_cnt_b), 32'd0);
    q_b.push_back(8'hC3);
    send_frame(1, 8'hC3, 27, 2, 1'b1, -1);
    wait_cyc(20);
    check_eq("after_rst_valid", 32'(tv_cyc_b), 32'd3);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1
    div_a = 16'd16;
    q_a.push_back(8'h07);
    send_frame(0, 8'h07, 16, 1, 1'b1, 1);
    wait_cyc(20);
    check_eq("par_ok_queue", 32'(q_a.size()), 32'd0);
    check_eq("par_ok_no_perr", 32'(pe_cnt_a), 32'd0);
    tv_cyc_a = 0;
    send_frame(0, 8'h07, 16, 1, 1'b1, 0);
    wait_cyc(20);
    check_eq("par_bad_pulse", 32'(pe_cnt_a), 32'd1);
    check_eq("par_bad_no_valid", 32'(tv_cyc_a), 32'd0);
`else
    check_eq("noparity_perr_a", 32'(pe_cnt_a), 32'd0);
`endif

    check_eq("final_queue_a", 32'(q_a.size()), 32'd0);
    check_eq("final_queue_b", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and the successor to the team's fixed-rate 8N1 receiver.
- Adds an input synchroniser, a run-time baud divisor, 5–9 data bits, and 1 or 2 stop bits.
- Adds framing/overrun error reporting and optional parity checking.
- Sits between the FPGA rx pin and an AXI-Stream-style byte consumer (command parser, FIFO).

Parameters:
- CLK_FREQ, 25_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: default baud rate; N_TICKS = CLK_FREQ/BAUD_RATE (217 at defaults).
- N_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits checked per frame; 1 or 2.
- DIV_W, 16: width of the run-time divisor port.
- PARITY_ODD, 0: 1 = odd parity, 0 = even. Used only when UART_RX_PARITY_EN is defined.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- rx_data, input, 1: asynchronous serial line; idles high.
- baud_div, input, DIV_W: clocks per bit. 0 selects N_TICKS; values 1..3 are clamped to 4.
- uart_rx_tdata, output, N_BITS: received word, LSB = first data bit.
- uart_rx_tvalid, output, 1: word available.
- uart_rx_tready, input, 1: consumer accepts the word.
- frame_err, output, 1: one-cycle pulse; a stop bit was sampled low.
- overrun, output, 1: one-cycle pulse; a word completed while the output register was still full.
- parity_err, output, 1: one-cycle pulse; parity mismatch. Tied 0 when the macro is off.

Behaviour:
- Reset (rst=1 on a clk edge):
  - Outputs: tvalid=0, tdata=0, frame_err=0, overrun=0, parity_err=0.
  - FSM goes to IDLE; tick and bit counters clear to 0.
  - Both synchroniser flops set to 1.
  - Reset mid-frame abandons the frame with no output and no error pulse.
- Synchroniser: two flops on rx_data; all logic uses the second flop (rxs). This adds 2 cycles of line latency.
- Divisor: the effective divisor D is latched on the IDLE→START transition. baud_div changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, DONE.
  - IDLE: on rxs=0 → START with tick=0.
  - START: count to (D-1)/2, then sample. If rxs=0 → DATA with tick=0, bit=0. If rxs=1, treat as a glitch and return to IDLE with no pulse.
  - DATA: every D ticks, sample rxs into shift[bit], then bit++. After bit N_BITS-1 is sampled → PARITY (macro on) or STOP.
  - PARITY: after D ticks, sample the parity bit and compare with the XOR of the data bits (inverted if PARITY_ODD). Then → STOP.
  - STOP: after D ticks, sample. A 0 on any stop bit sets the frame-error flag. Repeat STOP_BITS times, then → DONE.
  - DONE: one cycle, then → IDLE. Next start bit detection is therefore possible mid-stop-bit, which supports back-to-back frames.
- DONE actions, in priority order:
  1. Frame error: pulse frame_err; the word is discarded and tvalid/tdata are unchanged.
  2. Parity error (macro on, no frame error): pulse parity_err; the word is discarded.
  3. Output free (tvalid=0, or tvalid=1 with tready=1 this cycle): load tdata, tvalid=1 next cycle.
  4. Output full (tvalid=1, tready=0): pulse overrun; the new word is dropped and the old tdata is held.
- Handshake:
  - tvalid holds and tdata stays stable until a cycle with tready=1.
  - tvalid then drops, unless a new word loads in that same cycle.
  - tready while tvalid=0 has no effect.
- Latency: tvalid rises 1 cycle after the DONE cycle, i.e. 2 cycles after the last stop-bit sample.
- Counters: tick is DIV_W bits wide and clears on every sample; bit counter is $clog2(N_BITS+1) bits wide. No wrap occurs within a frame.

Optional Feature:
- UART_RX_PARITY_EN defined: frames carry one parity bit after the data bits. The PARITY state is compiled in, and parity_err is driven per PARITY_ODD.
- Undefined: no PARITY state, frames are start/data/stop only, and parity_err is tied 0.

Test Plan:
- Defaults, baud_div=0, send 0xA5 in 8N1 with tready=1 → exactly one tvalid cycle with tdata=0xA5; all error pulses stay 0.
- rx low for 50 cycles then high (D=217) → no tvalid, no error pulse, FSM back in IDLE.
- 0x3C sent with stop bit held 0 → one frame_err pulse, tvalid stays 0. Then a correct 0x3C frame → tdata=0x3C.
- tready=0, send 0x11 then 0x22 back-to-back → tdata=0x11 held, one overrun pulse. Then tready=1 for one cycle → tvalid drops.
- baud_div=27, STOP_BITS=2, send 0x5A then 0xFF with no idle gap → both words delivered in order. Then rst asserted mid-third-frame → no output, clean reception of the next frame.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 → tdata=0x07. 0x07 with parity bit 0 → one parity_err pulse, no tvalid.
